pit16: RTL and testbench

- 16-bit programmable interval timer: prescaler plus divider down-counters.
- Produces the zero/terminal-count event; it does not merely detect one.
- Sits on the internal CPU register bus and drives a one-cycle timer interrupt pulse to the interrupt controller.
- Period = (PRE+1)*(DIV+1) clocks.

---
 rtl/pit16_pkg.sv | 13 +
 rtl/pit16_down16.sv | 23 ++
 rtl/pit16.sv | 113 +++++++++++
 tb/tb_pit16.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pit16_pkg.sv
// Shared definitions for the pit16 interval timer: register map, reset values, CTRL bit layout.
package pit16_pkg;
  typedef enum logic [1:0] {
    PIT_PRE  = 2'd0,
    PIT_DIV  = 2'd1,
    PIT_STAT = 2'd2,
    PIT_CTRL = 2'd3
  } pit_addr_e;

  localparam int unsigned PIT_RST_PRE      = 0;
  localparam int unsigned PIT_RST_DIV      = 0;
  localparam int          PIT_CTRL_ONESHOT = 0;
endpackage

// File: rtl/pit16_down16.sv
// pit_down16: W-bit down-counter with synchronous load, decrement enable and combinational zero flag.
module pit_down16 #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_zero = ~|r_cnt;
endmodule

// File: rtl/pit16.sv
// pit16: prescaler x divider interval timer, period (PRE+1)*(DIV+1) clocks, one-cycle tint pulse.
// Optional one-shot mode (CTRL bit0) is built when PIT16_ONESHOT_EN is defined.
module pit16
  import pit16_pkg::*;
#(
  parameter int          W       = 16,
  parameter int unsigned RST_PRE = PIT_RST_PRE
) (
  input  logic         clk,
  input  logic         resetl,
  input  logic         wr,
  input  logic         rd,
  input  logic [1:0]   addr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         tint,
  output logic         running
);
  logic [W-1:0] r_pre_reg, r_div_reg, r_dout;
  logic         r_sticky, r_tint, r_running;
  logic [W-1:0] w_pre_cnt, w_div_cnt, w_div_reg_nx, w_ctrl_rd, w_rd_data;
  logic         w_pre_zero, w_div_zero;
  logic         w_wr_pre, w_wr_div, w_div_arm, w_count, w_tc, w_stop, w_done_nx, w_rd_stat;

  assign w_wr_pre  = wr && (addr == PIT_PRE);
  assign w_wr_div  = wr && (addr == PIT_DIV);
  assign w_rd_stat = rd && (addr == PIT_STAT);
  // Writing DIV=0 only stops the timer; a nonzero DIV write restarts both counters.
  assign w_div_arm = w_wr_div && (din != '0);
  // Any register write steals the cycle, so a write always beats a terminal count.
  assign w_count   = r_running && !wr;
  assign w_tc      = w_count && w_pre_zero && w_div_zero;
  assign w_div_reg_nx = w_wr_div ? din : r_div_reg;

`ifdef PIT16_ONESHOT_EN
  logic r_oneshot, r_done;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_oneshot <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (wr && (addr == PIT_CTRL)) r_oneshot <= din[PIT_CTRL_ONESHOT];
      r_done <= w_done_nx;
    end
  end

  assign w_stop    = w_tc && r_oneshot;
  assign w_done_nx = w_wr_div ? 1'b0 : (r_done || w_stop);
  always_comb begin
    w_ctrl_rd = '0;
    w_ctrl_rd[PIT_CTRL_ONESHOT] = r_oneshot;
  end
`else
  assign w_stop    = 1'b0;
  assign w_done_nx = 1'b0;
  assign w_ctrl_rd = '0;
`endif

  pit_down16 #(.W(W)) u_pre (
    .i_clk      (clk),
    .i_rst_n    (resetl),
    .i_load     (w_wr_pre || w_div_arm || (w_count && w_pre_zero && !w_stop)),
    .i_load_val (w_wr_pre ? din : r_pre_reg),
    .i_dec      (w_count && !w_pre_zero),
    .o_cnt      (w_pre_cnt),
    .o_zero     (w_pre_zero)
  );

  pit_down16 #(.W(W)) u_div (
    .i_clk      (clk),
    .i_rst_n    (resetl),
    .i_load     (w_div_arm || (w_tc && !w_stop)),
    .i_load_val (w_div_arm ? din : r_div_reg),
    .i_dec      (w_count && w_pre_zero && !w_div_zero),
    .o_cnt      (w_div_cnt),
    .o_zero     (w_div_zero)
  );

  always_comb begin
    w_rd_data = '0;
    case (addr)
      PIT_PRE:  w_rd_data = w_pre_cnt;
      PIT_DIV:  w_rd_data = w_div_cnt;
      PIT_STAT: w_rd_data = {{(W-1){1'b0}}, r_sticky};
      PIT_CTRL: w_rd_data = w_ctrl_rd;
      default:  w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_pre_reg <= W'(RST_PRE);
      r_div_reg <= W'(PIT_RST_DIV);
      r_dout    <= '0;
      r_sticky  <= 1'b0;
      r_tint    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      if (w_wr_pre) r_pre_reg <= din;
      r_div_reg <= w_div_reg_nx;
      if (rd) r_dout <= w_rd_data;
      // Set beats clear when a STATUS read lands on a terminal count.
      r_sticky  <= w_tc || (r_sticky && !w_rd_stat);
      r_tint    <= w_tc;
      r_running <= (w_div_reg_nx != '0) && !w_done_nx;
    end
  end

  assign dout    = r_dout;
  assign tint    = r_tint;
  assign running = r_running;
endmodule

// File: tb/tb_pit16.sv
// Scoreboard bench for pit16: driver runs a reference model and queues expected outputs, monitor compares.
module tb_pit16;
  logic        clk = 1'b0;
  logic        resetl = 1'b0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] din = 16'd0;
  logic [15:0] dout;
  logic        tint, running;

  pit16 #(.W(16)) dut (
    .clk(clk), .resetl(resetl), .wr(wr), .rd(rd), .addr(addr),
    .din(din), .dout(dout), .tint(tint), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tint;
    logic        running;
    logic [15:0] dout;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_pre_reg, m_div_reg, m_pre, m_div, m_dout;
  logic        m_sticky, m_tint, m_run, m_oneshot, m_done;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre_reg = 16'd0; m_div_reg = 16'd0; m_pre = 16'd0; m_div = 16'd0;
    m_dout = 16'd0; m_sticky = 1'b0; m_tint = 1'b0; m_run = 1'b0;
    m_oneshot = 1'b0; m_done = 1'b0;
  endtask

  function automatic logic tc_now();
    return m_run && (m_pre == 16'd0) && (m_div == 16'd0);
  endfunction

  // One clock of the timer's register-level behaviour, applied in rule order.
  task automatic model_step(input logic w, input logic r, input logic [1:0] a, input logic [15:0] d);
    logic en, tc;
    en = m_run && !w;
    tc = en && (m_pre == 16'd0) && (m_div == 16'd0);
    if (r) begin
      case (a)
        2'd0: m_dout = m_pre;
        2'd1: m_dout = m_div;
        2'd2: m_dout = {15'd0, m_sticky};
        default: m_dout = {15'd0, m_oneshot};
      endcase
      if (a == 2'd2) m_sticky = 1'b0;
    end
    if (tc) m_sticky = 1'b1;
    m_tint = tc;
    if (en) begin
      if (m_pre != 16'd0) m_pre = m_pre - 16'd1;
      else if (m_div != 16'd0) begin m_div = m_div - 16'd1; m_pre = m_pre_reg; end
      else if (m_oneshot) m_done = 1'b1;
      else begin m_div = m_div_reg; m_pre = m_pre_reg; end
    end
    if (w) begin
      case (a)
        2'd0: begin m_pre_reg = d; m_pre = d; end
        2'd1: begin
          if (d != 16'd0) begin m_div = d; m_pre = m_pre_reg; end
          m_div_reg = d;
          m_done = 1'b0;
        end
        2'd3: begin
`ifdef PIT16_ONESHOT_EN
          m_oneshot = d[0];
`endif
        end
        default: ;
      endcase
    end
    m_run = (m_div_reg != 16'd0) && !m_done;
  endtask

  task automatic cyc(input logic w, input logic r, input logic [1:0] a, input logic [15:0] d);
    exp_t e;
    wr = w; rd = r; addr = a; din = d;
    model_step(w, r, a, d);
    @(posedge clk);
    e.tint = m_tint; e.running = m_run; e.dout = m_dout;
    q.push_back(e);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic wait_tc();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tc_now()) begin hit = 1'b1; break; end
      idle(1);
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_tc: got timeout expected terminal count within 200 cycles");
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    #2;
    resetl = 1'b0;
    #1;
    chk("rst_tint", {15'd0, tint}, 16'd0);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_dout", dout, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetl = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("tint", {15'd0, tint}, {15'd0, e.tint});
      chk("running", {15'd0, running}, {15'd0, e.running});
      chk("dout", dout, e.dout);
    end
  end

  initial begin
    model_reset();
    #3;
    chk("por_tint", {15'd0, tint}, 16'd0);
    chk("por_running", {15'd0, running}, 16'd0);
    chk("por_dout", dout, 16'd0);
    @(posedge clk); #1;
    resetl = 1'b1;

    // Reset mid-count, then a quiet stretch with div_reg back at 0
    cyc(1, 0, 2'd0, 16'd3); cyc(1, 0, 2'd1, 16'd3);
    idle(7);
    hard_reset();
    idle(100);
    cyc(0, 1, 2'd0, 16'd0); cyc(0, 1, 2'd1, 16'd0);

    // Periodic PRE=1 DIV=2 and STATUS read/re-read
    cyc(1, 0, 2'd0, 16'd1); cyc(1, 0, 2'd1, 16'd2);
    idle(20);
    cyc(0, 1, 2'd2, 16'd0); cyc(0, 1, 2'd2, 16'd0);
    idle(2);

    // Prescaler bypass with live DIV reads
    cyc(1, 0, 2'd0, 16'd0); cyc(1, 0, 2'd1, 16'd4);
    idle(3); cyc(0, 1, 2'd1, 16'd0); idle(1); cyc(0, 1, 2'd1, 16'd0);
    idle(12);

    // Stop mid-period and restart
    cyc(1, 0, 2'd0, 16'd1); cyc(1, 0, 2'd1, 16'd3);
    idle(3);
    cyc(1, 0, 2'd1, 16'd0);
    idle(5); cyc(0, 1, 2'd0, 16'd0); cyc(0, 1, 2'd1, 16'd0);
    cyc(1, 0, 2'd1, 16'd2);
    idle(12);

    // Write colliding with terminal count, then STATUS read colliding with it
    cyc(0, 1, 2'd2, 16'd0);
    wait_tc();
    cyc(1, 0, 2'd0, 16'd1);
    idle(2); cyc(0, 1, 2'd2, 16'd0);
    wait_tc();
    cyc(0, 1, 2'd2, 16'd0); cyc(0, 1, 2'd2, 16'd0);

    // Read and write in the same cycle, plus a wide value
    cyc(1, 1, 2'd0, 16'd5);
    cyc(1, 0, 2'd0, 16'hABCD); cyc(0, 1, 2'd0, 16'd0); idle(2); cyc(0, 1, 2'd0, 16'd0);
    cyc(1, 0, 2'd0, 16'd0);

    // One-shot arm / re-arm (periodic when the option is not built)
    cyc(1, 0, 2'd3, 16'd1); cyc(1, 0, 2'd0, 16'd0); cyc(1, 0, 2'd1, 16'd3);
    idle(12); cyc(0, 1, 2'd3, 16'd0); cyc(0, 1, 2'd1, 16'd0);
    cyc(1, 0, 2'd1, 16'd3); idle(8);
    cyc(1, 0, 2'd3, 16'd0); idle(6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic w, r;
      logic [1:0] a;
      logic [15:0] d;
      w = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      d = (a <= 2'd1) ? 16'($urandom_range(0, 5)) : 16'($urandom_range(0, 3));
      cyc(w, r, a, d);
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
